// File: rtl/mdio_master.sv
// MDIO management master: divided MDC, Clause 22/45 frames with
// programmable preamble, read capture and absent-PHY detection.
module mdio_master #(
   parameter int unsigned CLK_DIV       = 10,
   parameter int unsigned PREAMBLE_BITS = 32,
   parameter bit          C45_EN        = 1'b1
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_c45,
   input  logic [1:0]  i_op,
   input  logic [4:0]  i_phy_addr,
   input  logic [4:0]  i_reg_addr,
   input  logic [15:0] i_wr_data,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_rd_data,
   output logic        o_error,
   output logic        o_mdc,
   output logic        o_mdio_o,
   output logic        o_mdio_oe,
   input  logic        i_mdio_i
);

   localparam int unsigned DIV_W = $clog2(CLK_DIV);
   localparam int unsigned CNT_W = 6;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_DONE
   } state_t;

   state_t             r_state,   w_state_nxt;
   logic [DIV_W-1:0]   r_div,     w_div_nxt;
   logic               r_mdc,     w_mdc_nxt;
   logic [CNT_W-1:0]   r_cnt,     w_cnt_nxt;
   logic [31:0]        r_sh,      w_sh_nxt;
   logic               r_rd,      w_rd_nxt;
   logic [15:0]        r_rx,      w_rx_nxt;
   logic               r_ta2,     w_ta2_nxt;
   logic               r_busy,    w_busy_nxt;
   logic               r_done,    w_done_nxt;
   logic [15:0]        r_rd_data, w_rd_data_nxt;
   logic               r_error,   w_error_nxt;
   logic               r_mdio_o,  w_mdio_o_nxt;
   logic               r_mdio_oe, w_mdio_oe_nxt;

   logic               w_c45;
   logic [31:0]        w_frame;
   logic               w_tick;
   state_t             w_adv;
   logic [CNT_W-1:0]   w_adv_cnt;

   // Frame word as latched at accept: ST, OP, PHYAD, REGAD, TA, DATA
   assign w_c45   = C45_EN && i_c45;
   assign w_frame = {(w_c45 ? 2'b00 : 2'b01), i_op, i_phy_addr, i_reg_addr, 2'b10, i_wr_data};
   assign w_tick  = (r_div == DIV_LAST);

   // State register and all datapath/output registers
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_div     <= '0;
         r_mdc     <= 1'b0;
         r_cnt     <= '0;
         r_sh      <= '0;
         r_rd      <= 1'b0;
         r_rx      <= '0;
         r_ta2     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rd_data <= '0;
         r_error   <= 1'b0;
         r_mdio_o  <= 1'b1;
         r_mdio_oe <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_div     <= w_div_nxt;
         r_mdc     <= w_mdc_nxt;
         r_cnt     <= w_cnt_nxt;
         r_sh      <= w_sh_nxt;
         r_rd      <= w_rd_nxt;
         r_rx      <= w_rx_nxt;
         r_ta2     <= w_ta2_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_rd_data <= w_rd_data_nxt;
         r_error   <= w_error_nxt;
         r_mdio_o  <= w_mdio_o_nxt;
         r_mdio_oe <= w_mdio_oe_nxt;
      end
   end

   // Next state: phase advance on each bit boundary (falling MDC)
   always_comb begin
      w_adv     = r_state;
      w_adv_cnt = r_cnt - CNT_W'(1);
      if (r_cnt == '0) begin
         case (r_state)
            S_PRE:   begin w_adv = S_HDR;  w_adv_cnt = CNT_W'(13); end
            S_HDR:   begin w_adv = S_TA;   w_adv_cnt = CNT_W'(1);  end
            S_TA:    begin w_adv = S_DATA; w_adv_cnt = CNT_W'(15); end
            default: begin w_adv = S_DONE; w_adv_cnt = '0;         end
         endcase
      end
   end

   // Next-state and output logic
   always_comb begin
      w_state_nxt   = r_state;
      w_div_nxt     = r_div;
      w_mdc_nxt     = r_mdc;
      w_cnt_nxt     = r_cnt;
      w_sh_nxt      = r_sh;
      w_rd_nxt      = r_rd;
      w_rx_nxt      = r_rx;
      w_ta2_nxt     = r_ta2;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_rd_data_nxt = r_rd_data;
      w_error_nxt   = r_error;
      w_mdio_o_nxt  = r_mdio_o;
      w_mdio_oe_nxt = r_mdio_oe;

      case (r_state)
         S_IDLE: begin
            w_div_nxt = '0;
            w_mdc_nxt = 1'b0;
            if (i_start) begin
               w_busy_nxt    = 1'b1;
               w_error_nxt   = 1'b0;
               w_rd_nxt      = i_op[1];
               w_mdio_oe_nxt = 1'b1;
               if (PREAMBLE_BITS != 0) begin
                  w_state_nxt  = S_PRE;
                  w_cnt_nxt    = CNT_W'(PREAMBLE_BITS - 1);
                  w_mdio_o_nxt = 1'b1;
                  w_sh_nxt     = w_frame;
               end else begin
                  w_state_nxt  = S_HDR;
                  w_cnt_nxt    = CNT_W'(13);
                  w_mdio_o_nxt = w_frame[31];
                  w_sh_nxt     = {w_frame[30:0], 1'b0};
               end
            end
         end

         S_PRE, S_HDR, S_TA, S_DATA: begin
            if (w_tick) begin
               w_div_nxt = '0;
               w_mdc_nxt = ~r_mdc;
            end else begin
               w_div_nxt = r_div + DIV_W'(1);
            end
            // Rising MDC: sample the PHY
            if (w_tick && !r_mdc) begin
               if (r_state == S_TA && r_cnt == '0) w_ta2_nxt = i_mdio_i;
               if (r_state == S_DATA)              w_rx_nxt  = {r_rx[14:0], i_mdio_i};
            end
            // Falling MDC: launch the next bit or finish the frame
            if (w_tick && r_mdc) begin
               w_state_nxt = w_adv;
               w_cnt_nxt   = w_adv_cnt;
               if (w_adv == S_DONE) begin
                  w_mdio_oe_nxt = 1'b0;
                  w_mdio_o_nxt  = 1'b1;
                  w_done_nxt    = 1'b1;
                  if (r_rd) begin
                     w_rd_data_nxt = r_rx;
                     w_error_nxt   = r_ta2;
                  end
               end else if (w_adv == S_PRE) begin
                  w_mdio_o_nxt  = 1'b1;
                  w_mdio_oe_nxt = 1'b1;
               end else begin
                  w_sh_nxt = {r_sh[30:0], 1'b0};
                  if (r_rd && w_adv != S_HDR) begin
                     w_mdio_o_nxt  = 1'b1;
                     w_mdio_oe_nxt = 1'b0;
                  end else begin
                     w_mdio_o_nxt  = r_sh[31];
                     w_mdio_oe_nxt = 1'b1;
                  end
               end
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_div_nxt   = '0;
            w_mdc_nxt   = 1'b0;
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_rd_data = r_rd_data;
   assign o_error   = r_error;
   assign o_mdc     = r_mdc;
   assign o_mdio_o  = r_mdio_o;
   assign o_mdio_oe = r_mdio_oe;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: two instances (A: CLK_DIV=4, 32-bit preamble;
// B: CLK_DIV=2, no preamble) driven by directed and random frames.
module tb_mdio_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start_a, start_b, c45;
   logic [1:0]  op;
   logic [4:0]  phy, regad;
   logic [15:0] wd;

   logic        busy_a, done_a, err_a, mdc_a, mdo_a, oe_a, mdi_a;
   logic        busy_b, done_b, err_b, mdc_b, mdo_b, oe_b, mdi_b;
   logic [15:0] rdd_a, rdd_b;

   mdio_master #(.CLK_DIV(4), .PREAMBLE_BITS(32), .C45_EN(1'b1)) u_a (
      .i_clock(clk), .i_reset(rst), .i_start(start_a), .i_c45(c45), .i_op(op),
      .i_phy_addr(phy), .i_reg_addr(regad), .i_wr_data(wd),
      .o_busy(busy_a), .o_done(done_a), .o_rd_data(rdd_a), .o_error(err_a),
      .o_mdc(mdc_a), .o_mdio_o(mdo_a), .o_mdio_oe(oe_a), .i_mdio_i(mdi_a));

   mdio_master #(.CLK_DIV(2), .PREAMBLE_BITS(0), .C45_EN(1'b1)) u_b (
      .i_clock(clk), .i_reset(rst), .i_start(start_b), .i_c45(c45), .i_op(op),
      .i_phy_addr(phy), .i_reg_addr(regad), .i_wr_data(wd),
      .o_busy(busy_b), .o_done(done_b), .o_rd_data(rdd_b), .o_error(err_b),
      .o_mdc(mdc_b), .o_mdio_o(mdo_b), .o_mdio_oe(oe_b), .i_mdio_i(mdi_b));

   int total = 0;
   int bad   = 0;

   // PHY model: per-bit response, bit index = number of MDC rises seen so far
   logic resp_a [0:63];
   logic resp_b [0:63];
   int   rise_a = 0;
   int   rise_b = 0;
   logic cap_o_a[$], cap_oe_a[$], cap_o_b[$], cap_oe_b[$];
   logic pm_a = 1'b0, pb_a = 1'b0, pm_b = 1'b0, pb_b = 1'b0;

   assign mdi_a = (rise_a < 64) ? resp_a[rise_a] : 1'b1;
   assign mdi_b = (rise_b < 64) ? resp_b[rise_b] : 1'b1;

   // Line monitor A: capture mdio at each MDC rise
   always @(negedge clk) begin
      if (busy_a && !pb_a) begin
         cap_o_a.delete(); cap_oe_a.delete(); rise_a <= 0;
      end
      if (mdc_a && !pm_a) begin
         cap_o_a.push_back(mdo_a); cap_oe_a.push_back(oe_a); rise_a <= rise_a + 1;
      end
      pm_a <= mdc_a; pb_a <= busy_a;
   end

   // Line monitor B
   always @(negedge clk) begin
      if (busy_b && !pb_b) begin
         cap_o_b.delete(); cap_oe_b.delete(); rise_b <= 0;
      end
      if (mdc_b && !pm_b) begin
         cap_o_b.push_back(mdo_b); cap_oe_b.push_back(oe_b); rise_b <= rise_b + 1;
      end
      pm_b <= mdc_b; pb_b <= busy_b;
   end

   bit          sel = 1'b0;
   logic        s_busy, s_done, s_err, s_mdc, s_mdo, s_oe;
   logic [15:0] s_rdd;
   assign s_busy = sel ? busy_b : busy_a;
   assign s_done = sel ? done_b : done_a;
   assign s_err  = sel ? err_b  : err_a;
   assign s_mdc  = sel ? mdc_b  : mdc_a;
   assign s_mdo  = sel ? mdo_b  : mdo_a;
   assign s_oe   = sel ? oe_b   : oe_a;
   assign s_rdd  = sel ? rdd_b  : rdd_a;

   logic [15:0] exp_rd_a = 16'h0, exp_rd_b = 16'h0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask

   task automatic set_start(input bit s, input logic v);
      if (s) start_b = v; else start_a = v;
   endtask

   task automatic scramble();
      c45 = 1'($urandom); op = 2'($urandom); phy = 5'($urandom);
      regad = 5'($urandom); wd = 16'($urandom);
   endtask

   // One complete frame with expectations computed from the frame rules
   task automatic run_frame(input bit s, input bit c45_i, input logic [1:0] op_i,
                            input logic [4:0] phy_i, input logic [4:0] reg_i,
                            input logic [15:0] wd_i, input logic [15:0] phy_val,
                            input bit ta2, input bit poke, input bit btb, input string tag);
      int pre, n, cdiv, len, cnt, mis_o, mis_oe;
      bit rd;
      logic [31:0] word;
      logic bits[$];
      logic r [0:63];
      logic eo[$], eoe[$];
      logic [15:0] e_rd;
      logic e_err, e_oe;
      sel  = s;
      pre  = s ? 0 : 32;
      cdiv = s ? 2 : 4;
      n    = pre + 32;
      len  = 2 * n * cdiv;
      rd   = op_i[1];
      for (int i = 0; i < 64; i++) r[i] = 1'b1;
      if (rd) begin
         r[pre + 15] = ta2;
         for (int j = 0; j < 16; j++) r[pre + 16 + j] = phy_val[15 - j];
      end
      if (s) resp_b = r; else resp_a = r;
      e_rd  = rd ? phy_val : (s ? exp_rd_b : exp_rd_a);
      e_err = rd ? ta2 : 1'b0;
      if (s) exp_rd_b = e_rd; else exp_rd_a = e_rd;
      word = {(c45_i ? 2'b00 : 2'b01), op_i, phy_i, reg_i, 2'b10, wd_i};
      for (int i = 0; i < pre; i++) bits.push_back(1'b1);
      for (int j = 31; j >= 0; j--) bits.push_back(word[j]);

      @(negedge clk);
      c45 = c45_i; op = op_i; phy = phy_i; regad = reg_i; wd = wd_i;
      set_start(s, 1'b1);
      @(posedge clk); #1;
      chk({tag, "/busy_at_accept"}, 32'(s_busy), 32'd1);
      chk({tag, "/err_at_accept"}, 32'(s_err), 32'd0);
      set_start(s, 1'b0);
      scramble();
      cnt = 0;
      while (cnt < len + 20 && s_done !== 1'b1) begin
         @(posedge clk); cnt++; #1;
         if (poke && cnt == 50) begin scramble(); set_start(s, 1'b1); end
         if (poke && cnt == 51) set_start(s, 1'b0);
      end
      chk({tag, "/len"}, 32'(cnt), 32'(len));
      chk({tag, "/oe_at_done"}, 32'(s_oe), 32'd0);
      chk({tag, "/mdo_at_done"}, 32'(s_mdo), 32'd1);
      chk({tag, "/rd_data"}, 32'(s_rdd), 32'(e_rd));
      chk({tag, "/error"}, 32'(s_err), 32'(e_err));
      if (s) begin eo = cap_o_b; eoe = cap_oe_b; end
      else   begin eo = cap_o_a; eoe = cap_oe_a; end
      chk({tag, "/nbits"}, 32'(eo.size()), 32'(n));
      mis_o = 0; mis_oe = 0;
      for (int i = 0; i < n && i < eo.size(); i++) begin
         e_oe = (!rd || i < pre + 14);
         if (eoe[i] !== e_oe) mis_oe++;
         if (e_oe && eo[i] !== bits[i]) mis_o++;
      end
      chk({tag, "/bit_errs"}, 32'(mis_o), 32'd0);
      chk({tag, "/oe_errs"}, 32'(mis_oe), 32'd0);
      if (btb) set_start(s, 1'b1);
      @(posedge clk); #1;
      chk({tag, "/done_width"}, 32'(s_done), 32'd0);
      chk({tag, "/busy_after"}, 32'(s_busy), 32'd0);
      set_start(s, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bit saw;
      logic r [0:63];
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
      c45 = 1'b0; op = 2'b00; phy = '0; regad = '0; wd = '0;
      for (int i = 0; i < 64; i++) begin resp_a[i] = 1'b1; resp_b[i] = 1'b1; end
      repeat (3) @(posedge clk);
      #1;
      chk("rst/mdc_a", 32'(mdc_a), 32'd0);
      chk("rst/mdo_a", 32'(mdo_a), 32'd1);
      chk("rst/oe_a", 32'(oe_a), 32'd0);
      chk("rst/busy_a", 32'(busy_a), 32'd0);
      chk("rst/done_a", 32'(done_a), 32'd0);
      chk("rst/err_a", 32'(err_a), 32'd0);
      chk("rst/rdd_a", 32'(rdd_a), 32'd0);
      chk("rst/busy_b", 32'(busy_b), 32'd0);
      chk("rst/mdo_b", 32'(mdo_b), 32'd1);
      @(negedge clk); rst = 1'b0;

      run_frame(0, 0, 2'b01, 5'd1, 5'd0, 16'h1140, 16'h0, 0, 0, 0, "c22_wr");
      run_frame(0, 0, 2'b10, 5'd3, 5'd2, 16'h0, 16'h0022, 0, 0, 0, "c22_rd");
      run_frame(0, 0, 2'b10, 5'd3, 5'd2, 16'h0, 16'hFFFF, 1, 0, 0, "c22_nophy");
      run_frame(0, 0, 2'b01, 5'd7, 5'd9, 16'hA5C3, 16'h0, 0, 1, 0, "wr_poke");
      run_frame(0, 1, 2'b00, 5'd0, 5'd1, 16'h0007, 16'h0, 0, 0, 1, "c45_addr");
      run_frame(0, 1, 2'b11, 5'd0, 5'd1, 16'h0, 16'hBEEF, 0, 0, 0, "c45_rd");
      run_frame(1, 0, 2'b01, 5'd2, 5'd4, 16'h8001, 16'h0, 0, 0, 0, "nopre_wr");
      run_frame(1, 1, 2'b10, 5'd31, 5'd31, 16'h0, 16'h1234, 0, 1, 0, "nopre_rd");

      // Reset in the middle of a write
      sel = 1'b0;
      for (int i = 0; i < 64; i++) r[i] = 1'b1;
      resp_a = r;
      @(negedge clk);
      c45 = 1'b0; op = 2'b01; phy = 5'd1; regad = 5'd0; wd = 16'hFFFF; start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      cnt = 0;
      while (rise_a < 20 && cnt < 1000) begin @(negedge clk); cnt++; end
      chk("rstmid/reach_bit20", 32'(rise_a >= 20), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rstmid/mdc", 32'(mdc_a), 32'd0);
      chk("rstmid/oe", 32'(oe_a), 32'd0);
      chk("rstmid/busy", 32'(busy_a), 32'd0);
      chk("rstmid/done", 32'(done_a), 32'd0);
      chk("rstmid/rdd", 32'(rdd_a), 32'd0);
      exp_rd_a = 16'h0; exp_rd_b = 16'h0;
      @(negedge clk); rst = 1'b0;
      saw = 1'b0;
      repeat (40) begin @(negedge clk); if (done_a) saw = 1'b1; end
      chk("rstmid/no_done", 32'(saw), 32'd0);
      run_frame(0, 0, 2'b01, 5'd1, 5'd0, 16'h1140, 16'h0, 0, 0, 0, "after_rst");

      // Random frames on both instances
      for (int k = 0; k < 8; k++) begin
         run_frame(1'(k % 2), 1'($urandom), 2'($urandom), 5'($urandom), 5'($urandom),
                   16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0),
                   1'($urandom), 1'($urandom), $sformatf("rand%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Parametrised MDIO management master for the Ethernet PHY; next generation of the original fixed-rate Clause 22 MDIO engine.
- Generates MDC from the system clock through a programmable divider.
- Supports Clause 22 and Clause 45 frames, a configurable preamble length (including preamble suppression), and detects an absent PHY via the turnaround bit.
- Sits between the PHY configuration sequencer and the top-level MDIO tristate buffer.

Parameters:
- CLK_DIV, 10, clock cycles per MDC half-period (legal range ≥2). MDC period = 2*CLK_DIV clocks.
- PREAMBLE_BITS, 32, number of preamble ones sent before ST (legal range 0..32; 0 = suppressed).
- C45_EN, 1, 1 = Clause 45 frames allowed; 0 = the c45 input is ignored and treated as 0.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only when busy=0.
- c45  in  1  1 = Clause 45 frame (ST=00); 0 = Clause 22 (ST=01).
- op  in  2  OP field. C22: 01 = write, 10 = read. C45: 00 = address, 01 = write, 11 = read, 10 = read-increment.
- phy_addr  in  5  PHYAD / PRTAD.
- reg_addr  in  5  REGAD / DEVAD.
- wr_data  in  16  write data, or the address word for a C45 address frame.
- busy  out  1  high from the accept cycle through the end of the frame.
- done  out  1  one-clock pulse at frame end.
- rd_data  out  16  last read data; updated at done of read frames only.
- error  out  1  set at done of a read frame if the sampled second TA bit ≠ 0; cleared at the next accept.
- mdc  out  1  management clock.
- mdio_o  out  1  MDIO output data.
- mdio_oe  out  1  MDIO output enable; 1 = drive.
- mdio_i  in  1  MDIO input from the pad.

Behaviour:
- Reset values: mdc=0, mdio_o=1, mdio_oe=0, busy=0, done=0, error=0, rd_data=0, state=IDLE. Reset mid-frame aborts the frame: these values take effect the next clock, and no done pulse is generated.
- Accept: in IDLE, start=1 latches c45, op, phy_addr, reg_addr and wr_data, and sets busy=1 in the same cycle. start is ignored while busy. Inputs may change after accept.
- Read classification: a frame is a read when op[1]=1. This covers C22 op 10 and C45 ops 10 and 11; C45 op 00 is not a read.
- Timing: a divider counter toggles mdc every CLK_DIV clocks while busy, and mdc stays 0 in IDLE.
  - mdio_o and mdio_oe change only on the clock in which mdc falls, or on accept for the first bit.
  - mdio_i is sampled on the clock in which mdc rises.
  - Each bit occupies one full MDC period, low phase first.
- States and bit counts:
  - PREAMBLE: PREAMBLE_BITS bits of 1, oe=1. Skipped when PREAMBLE_BITS=0.
  - HEADER: 14 bits, MSB first: ST(2), OP(2), phy_addr(5), reg_addr(5). oe=1.
  - TA: 2 bits. Write/address frames drive 1,0 with oe=1. Read frames set oe=0 for both bits; the second bit is sampled into the error flag.
  - DATA: 16 bits, MSB first. Write/address frames drive wr_data with oe=1. Read frames keep oe=0 and shift mdio_i into a 16-bit register.
  - DONE: entered on the falling mdc after the last data bit. Sets oe=0, mdio_o=1, pulses done for one clock, clears busy, and returns to IDLE the same clock.
- Frame length: (PREAMBLE_BITS+32)*2*CLK_DIV clocks from accept to done, ±1 clock for the register stage. The bench checks the exact count for the RTL, which must be deterministic and identical for reads and writes.
- Clause 22 with op 00 or 11: sent as given, with no protection. The frame is a read iff op[1]=1.
- A back-to-back start in the same cycle as done is ignored (busy is still 1). A start the following cycle is accepted.

Test Plan:
- CLK_DIV=4, C22 write: phy 1, reg 0, data 0x1140. Bits captured at mdc rise are 32×'1', 01 01 00001 00000 10 0001000101000000. Accept-to-done is 512±1 clocks, done is high for 1 clock, and oe=1 for the whole frame.
- C22 read: phy 3, reg 2; the PHY model drives 0 on TA bit 2, then 0x0022. Expect rd_data=0x0022, error=0, and oe=0 from the start of TA through done.
- C22 read with no PHY (mdio_i pulled to 1). Expect rd_data=0xFFFF and error=1. A following write clears error at accept.
- C45 address frame (op 00, devad 1, data 0x0007), then a read (op 11). The header starts 00 00 and 00 11 respectively; the read returns the model value 0xBEEF.
- PREAMBLE_BITS=0, CLK_DIV=2: the first mdc period carries ST bit 0, and the frame is 32 MDC periods = 128 clocks.
- Pulse start while busy: it is ignored, and the latched fields are unchanged. Assert reset at bit 20 of a write: the next clock shows mdc=0, oe=0, busy=0 with no done pulse, and a fresh start then completes normally.
